twiddle_stream: RTL and testbench

- Streaming, pipelined twiddle-factor multiplier placed between the two butterfly ranks of the radix-R FFT datapath.
- Accepts one complex sample per cycle in natural order, derives the twiddle exponent from a frame position counter, and multiplies by W_N^k.
- Generalises the fixed 16-point combinational stage in frame size, radix, data width and twiddle width.
- Adds valid/ready flow control, rounding, saturation and frame checking.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/twiddle_stream_if.sv | 31 +++
 rtl/twiddle_rom.sv | 41 ++++
 rtl/twiddle_stream.sv | 183 ++++++++++++++++++
 tb/tb_twiddle_stream.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath package: Q-format constants, quadrant codes, and the
// round/saturate helpers reused by the twiddle and butterfly stages.
package fft_pkg;

  localparam int unsigned TW_W_DEFAULT = 16;
  localparam int unsigned TW_FRAC      = TW_W_DEFAULT - 1;

  // Quadrant q selects the (-j)^q rotation applied after the multiply
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Clamp a wide signed value into the signed range of a w-bit word
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Round half-up, then drop frac fractional bits
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] x,
                                                   input int unsigned frac);
    return (x + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic logic signed [63:0] neg_sat(input logic signed [63:0] x,
                                                 input int unsigned w);
    return sat_w(-x, w);
  endfunction

endpackage

// File: rtl/twiddle_stream_if.sv
// Sample stream bus for twiddle_stream (input and output valid/ready channels).
// In TWIDDLE_STREAM_CONJ_EN builds the bus also carries in_inv.
interface twiddle_stream_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     in_last;
`ifdef TWIDDLE_STREAM_CONJ_EN
  logic                     in_inv;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     out_last;

`ifdef TWIDDLE_STREAM_CONJ_EN
  modport slave  (input  in_valid, in_re, in_im, in_last, in_inv, out_ready,
                  output in_ready, out_valid, out_re, out_im, out_last);
  modport master (output in_valid, in_re, in_im, in_last, in_inv, out_ready,
                  input  in_ready, out_valid, out_re, out_im, out_last);
`else
  modport slave  (input  in_valid, in_re, in_im, in_last, out_ready,
                  output in_ready, out_valid, out_re, out_im, out_last);
  modport master (output in_valid, in_re, in_im, in_last, out_ready,
                  input  in_ready, out_valid, out_re, out_im, out_last);
`endif
endinterface

// File: rtl/twiddle_rom.sv
// Quarter-wave cos/sin ROM in Q1.(TW_W-1), synchronous read; the table is
// computed at elaboration. Entry 0 (unity) is never used because m=0 bypasses.
module twiddle_rom #(
  parameter  int unsigned N_POINTS = 16,
  parameter  int unsigned TW_W     = 16,
  localparam int unsigned M_W      = $clog2(N_POINTS) - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [M_W-1:0]         i_addr,
  output logic signed [TW_W-1:0] o_cos,
  output logic signed [TW_W-1:0] o_sin
);
  localparam int unsigned DEPTH = N_POINTS / 4;
  localparam real         PI    = 3.14159265358979323846;
  localparam real         SCALE = 2.0 ** (TW_W - 1);
  localparam int          MAXV  = (1 << (TW_W - 1)) - 1;

  logic signed [TW_W-1:0] w_cos_tab [DEPTH];
  logic signed [TW_W-1:0] w_sin_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam real ANG   = 2.0 * PI * real'(g) / real'(N_POINTS);
    localparam int  COS_Q = $rtoi($cos(ANG) * SCALE + 0.5);
    localparam int  SIN_Q = $rtoi($sin(ANG) * SCALE + 0.5);
    assign w_cos_tab[g] = TW_W'((COS_Q > MAXV) ? MAXV : COS_Q);
    assign w_sin_tab[g] = TW_W'((SIN_Q > MAXV) ? MAXV : SIN_Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cos <= '0;
      o_sin <= '0;
    end else if (i_en) begin
      o_cos <= w_cos_tab[i_addr];
      o_sin <= w_sin_tab[i_addr];
    end
  end

endmodule

// File: rtl/twiddle_stream.sv
// Streaming twiddle multiplier between FFT butterfly ranks: stage 1 index/capture,
// stage 2 ROM read, stage 3 multiply/round/saturate/rotate. Macro TWIDDLE_STREAM_CONJ_EN adds in_inv.
module twiddle_stream
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned RADIX    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TW_W     = TW_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  twiddle_stream_if.slave bus,
  output logic            err_frame,
  input  logic            err_clr
);
  localparam int unsigned IDX_W  = $clog2(N_POINTS);
  localparam int unsigned COL_W  = $clog2(RADIX);
  localparam int unsigned ROW_W  = IDX_W - COL_W;
  localparam int unsigned M_W    = IDX_W - 2;
  localparam int unsigned FRAC_W = TW_W - 1;
  localparam int unsigned PROD_W = DATA_W + TW_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINTS - 1);

  function automatic logic signed [DATA_W-1:0] neg_d(input logic signed [DATA_W-1:0] x);
    return DATA_W'(neg_sat(64'(x), DATA_W));
  endfunction

  logic              w_en, w_fire, w_in_inv, w_idx_end, w_err_set;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_col;
  logic [IDX_W-1:0]  w_k;
  logic [1:0]        w_qbits, w_qeff;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err_frame;

  logic                     r1_valid, r1_last, r1_inv;
  logic signed [DATA_W-1:0] r1_re, r1_im;
  quad_e                    r1_q;
  logic [M_W-1:0]           r1_m;

  logic                     r2_valid, r2_last, r2_inv, r2_bypass;
  logic signed [DATA_W-1:0] r2_re, r2_im;
  quad_e                    r2_q;
  logic signed [TW_W-1:0]   w_cos, w_sin;

  logic signed [PROD_W-1:0] w_ac, w_bs, w_bc, w_as;
  logic signed [SUM_W-1:0]  w_sum_re, w_sum_im;
  logic signed [DATA_W-1:0] w_mul_re, w_mul_im, w_rot_re, w_rot_im;

  logic                     r_out_valid, r_out_last;
  logic signed [DATA_W-1:0] r_out_re, r_out_im;

  // Whole pipeline advances together unless a held output is being refused
  assign w_en         = bus.out_ready | ~r_out_valid;
  assign w_fire       = bus.in_valid & w_en;
  assign bus.in_ready = w_en;

`ifdef TWIDDLE_STREAM_CONJ_EN
  assign w_in_inv = bus.in_inv;
`else
  assign w_in_inv = 1'b0;
`endif

  // k = row*col of the N = RADIX*RADIX index split; the product wraps mod N by width
  assign w_row     = r_idx[IDX_W-1:COL_W];
  assign w_col     = r_idx[COL_W-1:0];
  assign w_k       = IDX_W'(w_row) * IDX_W'(w_col);
  assign w_qbits   = w_k[IDX_W-1 -: 2];
  assign w_qeff    = w_in_inv ? 2'(2'd0 - w_qbits) : w_qbits;
  assign w_idx_end = (r_idx == IDX_LAST);
  assign w_err_set = w_fire & (bus.in_last ^ w_idx_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_err_frame <= 1'b0;
    end else begin
      if (w_fire) r_idx <= (bus.in_last | w_idx_end) ? '0 : r_idx + IDX_W'(1);
      r_err_frame <= w_err_set | (r_err_frame & ~err_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_last  <= 1'b0;
      r1_inv   <= 1'b0;
      r1_re    <= '0;
      r1_im    <= '0;
      r1_q     <= Q0;
      r1_m     <= '0;
    end else if (w_en) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_last <= bus.in_last;
        r1_inv  <= w_in_inv;
        r1_re   <= bus.in_re;
        r1_im   <= bus.in_im;
        r1_q    <= quad_e'(w_qeff);
        r1_m    <= w_k[M_W-1:0];
      end
    end
  end

  twiddle_rom #(.N_POINTS(N_POINTS), .TW_W(TW_W)) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_addr (r1_m),
    .o_cos  (w_cos),
    .o_sin  (w_sin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_last   <= 1'b0;
      r2_inv    <= 1'b0;
      r2_bypass <= 1'b0;
      r2_re     <= '0;
      r2_im     <= '0;
      r2_q      <= Q0;
    end else if (w_en) begin
      r2_valid  <= r1_valid;
      r2_last   <= r1_last;
      r2_inv    <= r1_inv;
      r2_bypass <= (r1_m == '0);
      r2_re     <= r1_re;
      r2_im     <= r1_im;
      r2_q      <= r1_q;
    end
  end

  // W^m = c - j*s (conjugate flips s); one guard bit absorbs the sum
  assign w_ac     = PROD_W'(r2_re) * PROD_W'(w_cos);
  assign w_bs     = PROD_W'(r2_im) * PROD_W'(w_sin);
  assign w_bc     = PROD_W'(r2_im) * PROD_W'(w_cos);
  assign w_as     = PROD_W'(r2_re) * PROD_W'(w_sin);
  assign w_sum_re = r2_inv ? SUM_W'(w_ac) - SUM_W'(w_bs) : SUM_W'(w_ac) + SUM_W'(w_bs);
  assign w_sum_im = r2_inv ? SUM_W'(w_bc) + SUM_W'(w_as) : SUM_W'(w_bc) - SUM_W'(w_as);

  always_comb begin
    w_mul_re = r2_re;
    w_mul_im = r2_im;
    if (!r2_bypass) begin
      w_mul_re = DATA_W'(sat_w(round_shr(64'(w_sum_re), FRAC_W), DATA_W));
      w_mul_im = DATA_W'(sat_w(round_shr(64'(w_sum_im), FRAC_W), DATA_W));
    end
    w_rot_re = w_mul_re;
    w_rot_im = w_mul_im;
    unique case (r2_q)
      Q0: begin w_rot_re = w_mul_re;        w_rot_im = w_mul_im;        end
      Q1: begin w_rot_re = w_mul_im;        w_rot_im = neg_d(w_mul_re); end
      Q2: begin w_rot_re = neg_d(w_mul_re); w_rot_im = neg_d(w_mul_im); end
      Q3: begin w_rot_re = neg_d(w_mul_im); w_rot_im = w_mul_re;        end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_out_last <= r2_last;
        r_out_re   <= w_rot_re;
        r_out_im   <= w_rot_im;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign err_frame     = r_err_frame;

endmodule

// File: tb/tb_twiddle_stream.sv
// Bench for twiddle_stream: directed frames plus random backpressure, checked
// against a real-arithmetic twiddle model and a scoreboard queue.
module tb_twiddle_stream;
  localparam int N  = 16;
  localparam int R  = 4;
  localparam int DW = 16;
  localparam int TW = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic err_clr = 1'b0;
  logic err_frame;

  always #5 clk = ~clk;

  twiddle_stream_if #(.DATA_W(DW)) bus();

  twiddle_stream #(.N_POINTS(N), .RADIX(R), .DATA_W(DW), .TW_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_frame (err_frame),
    .err_clr   (err_clr)
  );

  typedef struct {
    int re;
    int im;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_idx  = 0;
  int   n_in   = 0;
  bit   exp_err = 1'b0;
  bit   lat_chk = 1'b0;
  bit   ovr_v [N];
  int   ovr_re [N];
  int   ovr_im [N];
  bit   prev_stall = 1'b0;
  int   prev_re, prev_im;
  bit   prev_last;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint clampd(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Twiddle reference: k from the index split, quantised cos/sin, then (-j)^q
  function automatic void model(input int idx, input int a, input int b, input bit inv,
                                output int ore, output int oim);
    int     k, qd, m;
    longint c, s, pr, pv;
    real    ang;
    k  = ((idx / R) * (idx % R)) % N;
    qd = k / (N / 4);
    m  = k % (N / 4);
    if (m == 0) begin
      pr = a;
      pv = b;
    end else begin
      ang = 2.0 * 3.141592653589793 * m / N;
      c   = longint'($rtoi($cos(ang) * 32768.0 + 0.5));
      s   = longint'($rtoi($sin(ang) * 32768.0 + 0.5));
      if (inv) s = -s;
      pr = clampd((longint'(a) * c + longint'(b) * s + 16384) >>> 15);
      pv = clampd((longint'(b) * c - longint'(a) * s + 16384) >>> 15);
    end
    if (inv) qd = (4 - qd) % 4;
    case (qd)
      0:       begin ore = int'(pr);          oim = int'(pv);          end
      1:       begin ore = int'(pv);          oim = int'(clampd(-pr)); end
      2:       begin ore = int'(clampd(-pr)); oim = int'(clampd(-pv)); end
      default: begin ore = int'(clampd(-pv)); oim = int'(pr);          end
    endcase
  endfunction

  task automatic clr_ovr();
    for (int i = 0; i < N; i++) ovr_v[i] = 1'b0;
  endtask

  task automatic set_ovr(input int idx, input int re, input int im);
    ovr_v[idx]  = 1'b1;
    ovr_re[idx] = re;
    ovr_im[idx] = im;
  endtask

  // One clock: drive at negedge, check outputs/err, update model, advance
  task automatic step(input bit v, input int re, input int im, input bit last,
                      input bit inv, input bit ordy, input bit clr);
    exp_t e;
    int   ore, oim;
    bit   set;
    bus.in_valid  = v;
    bus.in_re     = DW'(re);
    bus.in_im     = DW'(im);
    bus.in_last   = last;
`ifdef TWIDDLE_STREAM_CONJ_EN
    bus.in_inv    = inv;
`endif
    bus.out_ready = ordy;
    err_clr       = clr;
    #1;
    if (prev_stall) begin
      chk("stall_re", 32'($signed(bus.out_re)), prev_re);
      chk("stall_im", 32'($signed(bus.out_im)), prev_im);
      chk("stall_last", 32'(bus.out_last), 32'(prev_last));
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("out_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_re", 32'($signed(bus.out_re)), e.re);
        chk("out_im", 32'($signed(bus.out_im)), e.im);
        chk("out_last", 32'(bus.out_last), 32'(e.last));
        if (lat_chk) chk("latency", cyc - e.cyc, 3);
      end
    end
    chk("err_frame", 32'(err_frame), 32'(exp_err));
    set = 1'b0;
    if (bus.in_valid && bus.in_ready) begin
      model(m_idx, re, im, inv, ore, oim);
      if (ovr_v[m_idx]) begin
        ore = ovr_re[m_idx];
        oim = ovr_im[m_idx];
      end
      e.re = ore; e.im = oim; e.last = last; e.cyc = cyc;
      q.push_back(e);
      n_in++;
      set   = (last != (m_idx == N - 1));
      m_idx = (last || m_idx == N - 1) ? 0 : m_idx + 1;
    end
    exp_err    = set | (exp_err & ~clr);
    prev_stall = bus.out_valid & ~bus.out_ready;
    prev_re    = int'($signed(bus.out_re));
    prev_im    = int'($signed(bus.out_im));
    prev_last  = bus.out_last;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() > 0; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  initial begin
    int target;
    bit v, ordy;
    int burst;
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_last = 1'b0;
`ifdef TWIDDLE_STREAM_CONJ_EN
    bus.in_inv = 1'b0;
`endif
    bus.out_ready = 1'b0;
    clr_ovr();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_re", 32'($signed(bus.out_re)), 0);
    chk("rst_out_im", 32'($signed(bus.out_im)), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_err", 32'(err_frame), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant (1000,0) frame with the hand-derived twiddle results
    lat_chk = 1'b1;
    for (int i = 0; i <= 4; i++) set_ovr(i, 1000, 0);
    set_ovr(8, 1000, 0);
    set_ovr(5, 924, -383);
    set_ovr(6, 707, -707);
    set_ovr(10, 0, -1000);
    set_ovr(15, -924, 383);
    for (int i = 0; i < N; i++) step(1, 1000, 0, i == N - 1, 0, 1, 0);
    drain();
    clr_ovr();

    // Saturation corners at idx 8 (k=0) and idx 10 (q=1, m=0)
    set_ovr(8, -32768, -32768);
    set_ovr(10, 0, 32767);
    for (int i = 0; i < N; i++) begin
      if (i == 8)       step(1, -32768, -32768, 0, 0, 1, 0);
      else if (i == 10) step(1, -32768, 0, 0, 0, 1, 0);
      else              step(1, rnd16(), rnd16(), i == N - 1, 0, 1, 0);
    end
    drain();
    clr_ovr();

    // Early in_last at idx 7, restart at idx 0, then clear the sticky flag
    for (int i = 0; i < 8; i++) step(1, 1000, 0, i == 7, 0, 1, 0);
    chk("err_set", 32'(err_frame), 1);
    set_ovr(5, 924, -383);
    for (int i = 0; i < 6; i++) step(1, 1000, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("err_cleared", 32'(err_frame), 0);
    for (int i = 6; i < N; i++) step(1, 1000, 0, i == N - 1, 0, 1, 0);
    drain();
    clr_ovr();

    // Random traffic with random and burst backpressure
    lat_chk = 1'b0;
    target  = n_in + 64;
    burst   = 0;
    for (int it = 0; it < 2000 && n_in < target; it++) begin
      v = ($urandom_range(0, 3) != 0);
      if (burst > 0) begin
        ordy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        ordy  = 1'b0;
        burst = 4;
      end else begin
        ordy = 1'($urandom_range(0, 1));
      end
      step(v, rnd16(), rnd16(), m_idx == N - 1, 0, ordy, 0);
    end
    chk("bp_sent", n_in, target);
    drain();

`ifdef TWIDDLE_STREAM_CONJ_EN
    // Inverse twiddles
    lat_chk = 1'b1;
    set_ovr(5, 924, 383);
    set_ovr(7, 383, 924);
    for (int i = 0; i < N; i++) step(1, 1000, 0, i == N - 1, 1, 1, 0);
    drain();
    clr_ovr();
`endif

    // Reset in the middle of a frame with samples in flight and err set
    lat_chk = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 500, 500, i == 3, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_re", 32'($signed(bus.out_re)), 0);
    chk("mid_rst_im", 32'($signed(bus.out_im)), 0);
    chk("mid_rst_err", 32'(err_frame), 0);
    q.delete();
    m_idx = 0; exp_err = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    lat_chk = 1'b1;
    set_ovr(0, 1234, -567);
    step(1, 1234, -567, 0, 0, 1, 0);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
